// File: rtl/pc_sequencer_pkg.sv
// Shared instruction-format definitions for the program-counter sequencer.
// Opcode values and field positions mirror the ROM instruction encoding.
package pc_sequencer_pkg;

    localparam int unsigned INSTR_W        = 28;
    localparam int unsigned OPCODE_W       = 4;
    localparam int unsigned TARGET_W       = 8;
    localparam int unsigned OPERAND_W      = 16;
    localparam int unsigned RA_STACK_DEPTH = 8;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 4'h0,
        OP_JMP  = 4'h1,
        OP_STO  = 4'h2,
        OP_ADD  = 4'h3,
        OP_BLE  = 4'h4,
        OP_INC  = 4'h5,
        OP_CALL = 4'h6,
        OP_RET  = 4'h7,
        OP_MOV  = 4'h8,
        OP_VGA  = 4'h9
    } opcode_e;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;    // [27:24]
        logic [TARGET_W-1:0]  target;    // [23:16]
        logic [OPERAND_W-1:0] operands;  // [15:0]
    } instr_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO: synchronous push, combinational top-of-stack.
// The fill level is owned by the parent; a pop is just the parent decrementing it.
module return_stack #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              push_i,
    input  logic [CNT_W-1:0]  level_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] top_c,
    output logic              full_c,
    output logic              empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign full_c  = (level_i == CNT_W'(DEPTH));
    assign empty_c = (level_i == '0);

    // Entries carry no reset: only the level decides which ones are valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_c) begin
            mem_q[PTR_W'(level_i)] <= wdata_i;
        end
    end

    assign top_c = mem_q[PTR_W'(level_i - CNT_W'(1))];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow unit feeding the instruction ROM address.
// Handles sequential fetch, JMP, BLE and CALL/RET with a hardware return stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       STACK_DEPTH = RA_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iBranchTaken,
    input  logic               iStall,
    output logic [ADDR_W-1:0]  oAddress,
    output logic [3:0]         oStackDepth,
    output logic               oFault
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    instr_t            instr;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic              fault_q, fault_d;
    logic              push_c;
    logic [ADDR_W-1:0] top_c;
    logic              full_c;
    logic              empty_c;
    logic              unused_operands_c;

    assign instr             = instr_t'(iInstruction);
    assign pc_inc            = pc_q + ADDR_W'(1);
    assign target            = ADDR_W'(instr.target);
    // Operand field belongs to the datapath, not to control flow.
    assign unused_operands_c = ^instr.operands;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // A latched fault freezes everything; a stall only freezes this cycle.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push_c  = 1'b0;
        if (!fault_q && !iStall) begin
            case (instr.opcode)
                OP_JMP: pc_d = target;
                OP_BLE: pc_d = iBranchTaken ? target : pc_inc;
                OP_CALL: begin
                    if (full_c) begin
                        fault_d = 1'b1;
                    end else begin
                        push_c  = 1'b1;
                        depth_d = depth_q + CNT_W'(1);
                        pc_d    = target;
                    end
                end
                OP_RET: begin
                    if (empty_c) begin
                        fault_d = 1'b1;
                    end else begin
                        depth_d = depth_q - CNT_W'(1);
                        pc_d    = top_c;
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .CNT_W  (CNT_W)
    ) u_return_stack (
        .clk_i   (Clock),
        .push_i  (push_c),
        .level_i (depth_q),
        .wdata_i (pc_inc),
        .top_c   (top_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign oAddress    = pc_q;
    assign oStackDepth = 4'(depth_q);
    assign oFault      = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized instruction streams against a queue-based model.
module tb_pc_sequencer;

    localparam bit [3:0] T_NOP  = 4'h0;
    localparam bit [3:0] T_JMP  = 4'h1;
    localparam bit [3:0] T_STO  = 4'h2;
    localparam bit [3:0] T_BLE  = 4'h4;
    localparam bit [3:0] T_CALL = 4'h6;
    localparam bit [3:0] T_RET  = 4'h7;
    localparam int       M_DEPTH = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [27:0] iInstruction;
    logic        iBranchTaken;
    logic        iStall;
    logic [15:0] oAddress;
    logic [3:0]  oStackDepth;
    logic        oFault;

    pc_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iInstruction (iInstruction),
        .iBranchTaken (iBranchTaken),
        .iStall       (iStall),
        .oAddress     (oAddress),
        .oStackDepth  (oStackDepth),
        .oFault       (oFault)
    );

    always #5 Clock = ~Clock;

    // Reference state: program counter, return addresses as a queue, fault flag.
    int m_pc;
    int m_stk[$];
    bit m_fault;

    int lit_addr  = -1;
    int lit_depth = -1;
    int lit_fault = -1;
    int n_checks  = 0;
    int n_errors  = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge Clock) begin
        check("addr", int'(oAddress), m_pc);
        check("depth", int'(oStackDepth), m_stk.size());
        check("fault", int'(oFault), int'(m_fault));
        if (lit_addr >= 0) begin
            check("lit_addr", int'(oAddress), lit_addr);
            check("model_addr", m_pc, lit_addr);
        end
        if (lit_depth >= 0) check("lit_depth", int'(oStackDepth), lit_depth);
        if (lit_fault >= 0) check("lit_fault", int'(oFault), lit_fault);
    end

    function automatic logic [27:0] mk(input bit [3:0] op, input int tgt);
        logic [15:0] operand;
        operand = 16'($urandom);
        return {op, 8'(tgt), operand};
    endfunction

    task automatic model_reset();
        m_pc    = 0;
        m_stk.delete();
        m_fault = 1'b0;
    endtask

    // One clock: drive after the falling edge, step the model on the rising edge.
    task automatic cyc(input logic [27:0] ins, input bit br, input bit st,
                       input int la, input int ld, input int lf);
        bit [3:0] op;
        int       tgt;
        #1;
        Reset        = 1'b0;
        lit_addr     = -1;
        lit_depth    = -1;
        lit_fault    = -1;
        iInstruction = ins;
        iBranchTaken = br;
        iStall       = st;
        op           = ins[27:24];
        tgt          = int'(ins[23:16]);
        @(posedge Clock);
        if (!m_fault && !st) begin
            case (op)
                T_JMP: m_pc = tgt;
                T_BLE: m_pc = br ? tgt : (m_pc + 1) % 65536;
                T_CALL: begin
                    if (m_stk.size() < M_DEPTH) begin
                        m_stk.push_back((m_pc + 1) % 65536);
                        m_pc = tgt;
                    end else begin
                        m_fault = 1'b1;
                    end
                end
                T_RET: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else                  m_fault = 1'b1;
                end
                default: m_pc = (m_pc + 1) % 65536;
            endcase
        end
        lit_addr  = la;
        lit_depth = ld;
        lit_fault = lf;
        @(negedge Clock);
    endtask

    // Asynchronous reset asserted just after a rising edge, checked in the same cycle.
    task automatic do_reset();
        @(posedge Clock);
        #1;
        Reset     = 1'b1;
        model_reset();
        lit_addr  = 0;
        lit_depth = 0;
        lit_fault = 0;
        @(negedge Clock);
    endtask

    function automatic logic [27:0] rand_instr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 30) return mk(4'($urandom_range(0, 15)), $urandom_range(0, 255));
        if (r < 45) return mk(T_JMP, $urandom_range(0, 255));
        if (r < 60) return mk(T_BLE, $urandom_range(0, 255));
        if (r < 80) return mk(T_CALL, $urandom_range(0, 255));
        return mk(T_RET, $urandom_range(0, 255));
    endfunction

    initial begin
        Reset        = 1'b1;
        iInstruction = '0;
        iBranchTaken = 1'b0;
        iStall       = 1'b0;
        model_reset();
        @(negedge Clock);

        // Sequential fetch, then a stall that must ignore a CALL.
        cyc(mk(T_NOP, 0), 0, 0, 1, 0, 0);
        cyc(mk(T_STO, 0), 0, 0, 2, 0, 0);
        cyc(mk(T_NOP, 0), 0, 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) cyc(mk(T_CALL, 9), 1, 1, 3, 0, 0);

        // CALL 57 at 5, RET at 67 returns to 6.
        cyc(mk(T_NOP, 0), 0, 0, 4, 0, 0);
        cyc(mk(T_NOP, 0), 0, 0, 5, 0, 0);
        cyc(mk(T_CALL, 57), 0, 0, 57, 1, 0);
        for (int a = 58; a <= 67; a++) cyc(mk(T_STO, 0), 0, 0, a, 1, 0);
        cyc(mk(T_RET, 0), 0, 0, 6, 0, 0);

        // BLE at 63, taken and not taken.
        cyc(mk(T_JMP, 63), 0, 0, 63, 0, 0);
        cyc(mk(T_BLE, 59), 1, 0, 59, 0, 0);
        cyc(mk(T_JMP, 63), 0, 0, 63, 0, 0);
        cyc(mk(T_BLE, 59), 0, 0, 64, 0, 0);

        // Two-instruction idle loop between 43 and 44.
        cyc(mk(T_JMP, 44), 0, 0, 44, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(mk(T_JMP, 43), 0, 0, 43, 0, 0);
            cyc(mk(T_NOP, 0), 0, 0, 44, 0, 0);
        end

        // Reset mid-run at PC 0x25 with three live stack entries.
        do_reset();
        cyc(mk(T_CALL, 8'h10), 0, 0, 8'h10, 1, 0);
        cyc(mk(T_CALL, 8'h20), 0, 0, 8'h20, 2, 0);
        cyc(mk(T_CALL, 8'h25), 0, 0, 8'h25, 3, 0);
        do_reset();

        // Overflow on the ninth nested CALL, then frozen until reset.
        for (int i = 1; i <= 8; i++) cyc(mk(T_CALL, i), 0, 0, i, i, 0);
        cyc(mk(T_CALL, 9), 0, 0, 8, 8, 1);
        cyc(mk(T_JMP, 3), 0, 0, 8, 8, 1);
        cyc(mk(T_RET, 0), 0, 0, 8, 8, 1);
        do_reset();

        // Underflow on RET at depth 0.
        cyc(mk(T_RET, 0), 0, 0, 0, 0, 1);
        cyc(mk(T_NOP, 0), 0, 0, 0, 0, 1);
        do_reset();

        // Randomized streams with occasional resets, more often after a fault.
        for (int n = 0; n < 4000; n++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(rand_instr(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 15), -1, -1, -1);
            end
        end

        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
